// File: rtl/fpc_rr_tlp.sv
// Turns accepted read requests into 16-DW Memory Read TLPs on a 64-bit AXI-stream TX port.
// A 3DW header is used when the byte address fits in 32 bits; the in-flight read count gates issue.
//
// state | meaning
// IDLE  | no TLP in progress, waiting for a request
// BEAT0 | presenting header DW1:DW0
// BEAT1 | presenting address DWs, last beat of the TLP
module fpc_rr_tlp #(
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pci_id,
  input  logic        rrm_valid,
  input  logic [54:0] rrm_addr,
  input  logic [7:0]  rrm_tag,
  output logic        rrm_ready,
  output logic [63:0] tx_tdata,
  output logic [7:0]  tx_tkeep,
  output logic        tx_tlast,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic        cpl_done,
  output logic [7:0]  outstanding
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

  localparam logic [8:0] MAX_OS = 9'(MAX_OUTSTANDING);

  state_e      state_q, state_d;
  logic [54:0] addr_q, addr_d;
  logic        is4_q, is4_d;
  logic [7:0]  tag_q, tag_d;
  logic [15:0] pid_q, pid_d;
  logic [7:0]  out_q, out_d;

  logic [63:0] byte_addr;
  logic [31:0] dw0, dw1;
  logic        can_issue, next_ok, accept, inc, dec;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    is4_d     = is4_q;
    tag_d     = tag_q;
    pid_d     = pid_q;
    out_d     = out_q;
    rrm_ready = 1'b0;
    tx_tvalid = 1'b0;
    tx_tlast  = 1'b0;
    tx_tkeep  = 8'h00;
    tx_tdata  = 64'h0;

    byte_addr = {3'b000, addr_q, 6'b000000};
    dw0       = is4_q ? 32'h2000_0010 : 32'h0000_0010;
    dw1       = {pid_q, tag_q, 4'hF, 4'hF};
    can_issue = {1'b0, out_q} < MAX_OS;
    // Issuing from BEAT1 must leave room for the TLP that is just finishing.
    next_ok   = ({1'b0, out_q} + 9'd1) < MAX_OS;

    case (state_q)
      IDLE: begin
        rrm_ready = can_issue & reset;
      end
      BEAT0: begin
        tx_tvalid = 1'b1;
        tx_tdata  = {dw1, dw0};
        tx_tkeep  = 8'hFF;
        if (tx_tready) state_d = BEAT1;
      end
      BEAT1: begin
        tx_tvalid = 1'b1;
        tx_tlast  = 1'b1;
        rrm_ready = tx_tready & next_ok & reset;
        if (is4_q) begin
          tx_tdata = {byte_addr[31:0], byte_addr[63:32]};
          tx_tkeep = 8'hFF;
        end else begin
          tx_tdata = {32'h0, byte_addr[31:0]};
          tx_tkeep = 8'h0F;
        end
        if (tx_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = rrm_valid & rrm_ready;
    if (accept) begin
      state_d = BEAT0;
      addr_d  = rrm_addr;
      is4_d   = |rrm_addr[54:26];
      tag_d   = rrm_tag;
      pid_d   = pci_id;
    end

    inc = (state_q == BEAT1) & tx_tready;
    dec = cpl_done & (out_q != 8'd0);
    case ({inc, dec})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   out_d = out_q - 8'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      is4_q   <= 1'b0;
      tag_q   <= '0;
      pid_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      is4_q   <= is4_d;
      tag_q   <= tag_d;
      pid_q   <= pid_d;
      out_q   <= out_d;
    end
  end

  assign outstanding = out_q;

endmodule

// File: doc/fpc_rr_tlp.md
Name: fpc_rr_tlp

Overview:
- Downstream stage of the read-request multiplexer: accepts one multiplexed read request per handshake (`rrm_*`: 64-byte-aligned address, 8-bit tag).
- Formats each request as a PCIe Memory Read TLP of 16 DW (64 bytes) on the 64-bit AXI-stream TX interface of the PCIe core.
- Selects a 3DW header when the upper 32 address bits are zero and a 4DW header otherwise.
- Enforces a limit on outstanding non-posted reads, using completion-done pulses from the completion unit.

Parameters:
MAX_OUTSTANDING, 32, maximum read requests in flight (1..255); issue stalls at this count.

Ports:
clock  input  1  core clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
pci_id  input  16  requester ID (bus/dev/fn), sampled when a request is accepted
rrm_valid  input  1  request valid
rrm_addr  input  55  request address in 64-byte units; byte address = {3'b0, rrm_addr, 6'b0}
rrm_tag  input  8  TLP tag
rrm_ready  output  1  request accepted when rrm_valid & rrm_ready
tx_tdata  output  64  TLP data; DW0 in [31:0], DW1 in [63:32]
tx_tkeep  output  8  byte enables
tx_tlast  output  1  last beat of TLP
tx_tvalid  output  1  beat valid
tx_tready  input  1  core accepts beat
cpl_done  input  1  one-cycle pulse: one read fully completed
outstanding  output  8  current in-flight count

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release): state IDLE; outstanding=0; tx_tvalid=0, tx_tlast=0, tx_tkeep=0, tx_tdata=0; rrm_ready=0 during reset.
- Outstanding limit: can_issue = (outstanding < MAX_OUTSTANDING).
- rrm_ready: combinational.
  - In IDLE: rrm_ready = can_issue.
  - In BEAT1: rrm_ready = tx_tready & (outstanding+1 < MAX_OUTSTANDING), which allows back-to-back TLPs.
  - In all other states: 0.
- Accept: capture the request registers:
  - byte address A[63:0] = {3'b0, rrm_addr, 6'b0}.
  - is4 = (rrm_addr[54:26] != 0).
  - tag, pci_id.
- Header fields:
  - DW0 = is4 ? 32'h2000_0010 : 32'h0000_0010 (MRd, TC0, attr 0, length 16).
  - DW1 = {pci_id, tag, 4'hF, 4'hF}.
  - 4DW: DW2 = A[63:32], DW3 = A[31:0].
  - 3DW: DW2 = A[31:0].
- States:
  - IDLE: on accept -> BEAT0, next cycle.
  - BEAT0: tx_tvalid=1, tdata={DW1,DW0}, tkeep=8'hFF, tlast=0. On tx_tready -> BEAT1.
  - BEAT1: tx_tvalid=1, tlast=1.
    - 4DW: tdata={DW3,DW2}, tkeep=8'hFF.
    - 3DW: tdata={32'h0,DW2}, tkeep=8'h0F.
    - On tx_tready: if a new request is accepted that same cycle -> BEAT0, else -> IDLE.
- Latency: accept -> first beat valid in the next cycle. Steady-state throughput is one TLP per 2 cycles with tready held high.
- Backpressure: tdata/tkeep/tlast/tvalid hold stable while tvalid & ~tready; no beat is dropped or repeated.
- Outstanding counter:
  - +1 on the BEAT1 handshake (TLP fully sent).
  - -1 on cpl_done.
  - Both in the same cycle: unchanged.
  - cpl_done while outstanding==0: ignored (no underflow).
  - Never exceeds MAX_OUTSTANDING.
- Request data accepted is owned by this block; rrm_addr/rrm_tag may change after the handshake.
- Reset mid-TLP: output drops immediately (tvalid=0). The partial TLP is abandoned; the PCIe core reset accompanies this reset.

Test Plan:
- 3DW request: pci_id=16'h0100, rrm_tag=8'h05, rrm_addr=55'h1, tready=1.
  - Required beat0 = 64'h010005FF_00000010, tkeep FF, tlast 0.
  - Required beat1 tdata[31:0] = 32'h0000_0040, tkeep 0F, tlast 1.
  - Required: outstanding becomes 1.
- 4DW request: rrm_addr=55'h400_0000, tag 8'h05.
  - Required beat0 = 64'h010005FF_20000010.
  - Required beat1 = 64'h00000000_00000001, tkeep FF.
- Backpressure: tready low for 3 cycles in BEAT0 and 2 cycles in BEAT1 -> tdata/tkeep/tlast stable throughout; exactly 2 beats transferred.
- Back-to-back: rrm_valid held, 4 requests, tready=1 -> 8 consecutive valid beats, no idle cycle; outstanding=4.
- Limit: MAX_OUTSTANDING=2.
  - Issue 2 requests -> rrm_ready=0.
  - Pulse cpl_done -> outstanding=1 and rrm_ready=1 next cycle.
  - cpl_done coincident with a BEAT1 handshake -> count unchanged.
  - cpl_done at 0 -> count stays 0.
- Reset: assert reset (low) during BEAT1 -> tvalid=0 and outstanding=0 immediately; after release, a fresh request is formatted correctly.
